elastic_repeater_bank: RTL and testbench

- Parametrised, multi-channel successor to the fixed single-driver buffer/inverter net connections in our placed netlists.
- Each channel carries a WIDTH-bit net bundle through STAGES registered repeater stages.
- Each channel has its own valid/ready back-pressure, synchronous flush and occupancy count.
- Sits between driver cells and distant sinks, so long routes can be retimed without breaking the handshake.

---
 rtl/elastic_repeater_bank.sv | 103 ++++++++++
 tb/tb_elastic_repeater_bank.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_repeater_bank.sv
`default_nettype none
// ============================================================================
// Module      : elastic_repeater_bank
// Description : Multi-channel registered repeater chain with per-channel
//               valid/ready back-pressure, flush and occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_repeater_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8,
    parameter int STAGES   = 3,
    parameter int CNT_W    = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    input  logic [CHANNELS-1:0]       flush,
    output logic [CHANNELS*CNT_W-1:0] occupancy
);

    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(STAGES);

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_chan
            logic [STAGES-1:0] r_valid;
            logic [WIDTH-1:0]  r_data [STAGES];
            logic [CNT_W-1:0]  r_cnt;
            logic [STAGES-1:0] w_adv;
            logic              w_hole;
            logic              w_push;
            logic              w_pop;

            // A stage may load when it or any stage downstream of it is empty,
            // or when the sink is draining the output stage.
            always_comb begin
                w_hole = out_ready[c];
                w_adv  = '0;
                for (int k = STAGES - 1; k >= 0; k--) begin
                    w_hole   = w_hole | ~r_valid[k];
                    w_adv[k] = w_hole;
                end
            end

            assign in_ready[c] = ~flush[c] & w_adv[0];
            assign w_push      = in_valid[c] & in_ready[c];
            assign w_pop       = r_valid[STAGES-1] & out_ready[c];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_valid <= '0;
                    r_cnt   <= '0;
                    for (int k = 0; k < STAGES; k++) begin
                        r_data[k] <= '0;
                    end
                end else begin
                    if (w_adv[0]) begin
                        r_valid[0] <= w_push;
                        if (w_push) begin
                            r_data[0] <= in_data[c*WIDTH +: WIDTH];
                        end
                    end
                    for (int k = 1; k < STAGES; k++) begin
                        if (w_adv[k]) begin
                            r_valid[k] <= r_valid[k-1];
                            if (r_valid[k-1]) begin
                                r_data[k] <= r_data[k-1];
                            end
                        end
                    end
                    // Flush overrides the shift; a pop in the same cycle has
                    // already been taken by the sink.
                    if (flush[c]) begin
                        r_valid <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
                    end
                end
            end

            assign out_valid[c]                 = r_valid[STAGES-1];
            assign out_data[c*WIDTH +: WIDTH]   = r_data[STAGES-1];
            assign occupancy[c*CNT_W +: CNT_W]  = r_cnt;

`ifndef SYNTHESIS
            always @(posedge clk) begin
                if (rst_n) begin
                    assert (r_cnt <= c_max_cnt);
                    assert (int'(r_cnt) == $countones(r_valid));
                end
            end
`endif
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_elastic_repeater_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_elastic_repeater_bank
// Description : Table-driven and scoreboard bench for elastic_repeater_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_repeater_bank;

    localparam int CH = 4;
    localparam int W  = 8;
    localparam int ST = 3;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [CH-1:0]   in_valid, in_ready, out_valid, out_ready, flush;
    logic [CH*W-1:0] in_data, out_data;
    logic [CH*CW-1:0] occupancy;

    always #5 clk = ~clk;

    elastic_repeater_bank #(
        .CHANNELS (CH),
        .WIDTH    (W),
        .STAGES   (ST),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    bit         rst_seen = 1'b0;
    logic [W-1:0] sbq [CH][$];

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       ev;
        logic [7:0] ed;
        logic       er;
        logic [1:0] eo;
    } vec_t;
    vec_t vt [7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input logic v, input logic [7:0] d);
        in_valid[c]        = v;
        in_data[c*W +: W]  = d;
    endtask

    task automatic wait_empty(input int c);
        int k = 0;
        while (occupancy[c*CW +: CW] != 2'd0 && k < 20) begin
            step();
            k++;
        end
        chk($sformatf("drain_ch%0d", c), 64'(occupancy[c*CW +: CW]), 64'd0);
    endtask

    // Scoreboard: transfers are decided at the negedge from the values that
    // will be present at the following posedge.
    always @(negedge clk) begin
        if (rst_seen) begin
            for (int c = 0; c < CH; c++) begin
                chk($sformatf("occ_vs_model_ch%0d", c),
                    64'(occupancy[c*CW +: CW]), 64'(sbq[c].size()));
            end
        end
        if (!rst_n) begin
            for (int c = 0; c < CH; c++) sbq[c].delete();
            rst_seen = 1'b1;
        end else begin
            for (int c = 0; c < CH; c++) begin
                if (out_valid[c] && out_ready[c]) begin
                    n_cmp++;
                    if (sbq[c].size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_word_ch%0d: got %0h expected none",
                                 c, out_data[c*W +: W]);
                    end else begin
                        logic [W-1:0] e;
                        e = sbq[c].pop_front();
                        if (out_data[c*W +: W] !== e) begin
                            n_err++;
                            $display("FAIL order_ch%0d: got %0h expected %0h",
                                     c, out_data[c*W +: W], e);
                        end
                    end
                end
                if (flush[c]) sbq[c].delete();
                else if (in_valid[c] && in_ready[c]) sbq[c].push_back(in_data[c*W +: W]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //           iv    id     ordy  ev    ed     er    eo
        vt[0] = '{1'b1, 8'h11, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};
        vt[1] = '{1'b1, 8'h22, 1'b1, 1'b0, 8'h00, 1'b1, 2'd1};
        vt[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 8'h00, 1'b1, 2'd2};
        vt[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b1, 2'd3};
        vt[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b1, 2'd2};
        vt[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b1, 2'd1};
        vt[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 2'd0};

        // Reset with traffic presented: nothing may emerge afterwards.
        rst_n     = 1'b0;
        in_valid  = '1;
        in_data   = 32'hDEADBEEF;
        out_ready = '1;
        flush     = '0;
        repeat (2) step();
        rst_n    = 1'b1;
        in_valid = '0;
        in_data  = '0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'hF);
        chk("rst_out_data",  64'(out_data),  64'd0);
        repeat (4) step();
        chk("rst_idle_out_valid", 64'(out_valid), 64'd0);

        // Latency and streaming on ch0.
        for (int i = 0; i < 7; i++) begin
            drive(0, vt[i].iv, vt[i].id);
            out_ready[0] = vt[i].ordy;
            #1;
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid[0]), 64'(vt[i].ev));
            if (vt[i].ev)
                chk($sformatf("tbl%0d_out_data", i), 64'(out_data[7:0]), 64'(vt[i].ed));
            chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready[0]), 64'(vt[i].er));
            chk($sformatf("tbl%0d_occ", i), 64'(occupancy[1:0]), 64'(vt[i].eo));
            step();
        end
        drive(0, 1'b0, 8'h00);

        // Back-pressure on ch1.
        out_ready[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b1, 8'hA0 + 8'(i));
            step();
        end
        drive(1, 1'b1, 8'hA3);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready",  64'(in_ready[1]),  64'd0);
            chk("bp_occ",       64'(occupancy[3:2]), 64'd3);
            chk("bp_out_valid", 64'(out_valid[1]), 64'd1);
            chk("bp_stable_data", 64'(out_data[15:8]), 64'hA0);
            step();
        end
        out_ready[1] = 1'b1;
        #1;
        chk("bp_release_in_ready", 64'(in_ready[1]), 64'd1);
        step();
        drive(1, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("bp_stream_valid", 64'(out_valid[1]), 64'd1);
            chk("bp_stream_data",  64'(out_data[15:8]), 64'(8'hA1 + 8'(i)));
            step();
        end
        wait_empty(1);

        // Full channel push+pop on ch2.
        out_ready[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(2, 1'b1, 8'hC0 + 8'(i));
            step();
        end
        drive(2, 1'b0, 8'h00);
        #1;
        chk("full_occ",      64'(occupancy[5:4]), 64'd3);
        chk("full_in_ready", 64'(in_ready[2]),    64'd0);
        out_ready[2] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(2, 1'b1, 8'hC3 + 8'(i));
            #1;
            chk("pp_in_ready", 64'(in_ready[2]),    64'd1);
            chk("pp_occ",      64'(occupancy[5:4]), 64'd3);
            step();
        end
        drive(2, 1'b0, 8'h00);
        #1;
        chk("pp_occ_after", 64'(occupancy[5:4]), 64'd3);
        wait_empty(2);

        // Flush on ch3 while ch0 streams.
        out_ready[3] = 1'b0;
        drive(3, 1'b1, 8'hD0);
        step();
        drive(3, 1'b1, 8'hD1);
        step();
        #1;
        chk("fl_pre_occ", 64'(occupancy[7:6]), 64'd2);
        drive(3, 1'b1, 8'hDF);
        flush[3]     = 1'b1;
        drive(0, 1'b1, 8'hE0);
        out_ready[0] = 1'b1;
        #1;
        chk("fl_in_ready",     64'(in_ready[3]), 64'd0);
        chk("fl_ch0_in_ready", 64'(in_ready[0]), 64'd1);
        step();
        flush[3] = 1'b0;
        drive(3, 1'b0, 8'h00);
        drive(0, 1'b1, 8'hE1);
        #1;
        chk("fl_post_occ",   64'(occupancy[7:6]), 64'd0);
        chk("fl_post_valid", 64'(out_valid[3]),   64'd0);
        step();
        drive(0, 1'b0, 8'h00);
        out_ready[3] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("fl_no_stale", 64'(out_valid[3]), 64'd0);
            step();
        end
        wait_empty(0);

        // Reset mid-operation with every channel half full.
        out_ready = '0;
        for (int c = 0; c < CH; c++) drive(c, 1'b1, 8'h60 + 8'(c));
        step();
        for (int c = 0; c < CH; c++) drive(c, 1'b1, 8'h70 + 8'(c));
        step();
        for (int c = 0; c < CH; c++)
            chk($sformatf("mid_occ_ch%0d", c), 64'(occupancy[c*CW +: CW]), 64'd2);
        in_valid = '1;
        rst_n    = 1'b0;
        step();
        rst_n    = 1'b1;
        in_valid = '0;
        #1;
        chk("mid_rst_occ",      64'(occupancy), 64'd0);
        chk("mid_rst_valid",    64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready),  64'hF);
        out_ready = '1;
        drive(0, 1'b1, 8'h5A);
        step();
        drive(0, 1'b0, 8'h00);
        chk("lat_n0", 64'(out_valid[0]), 64'd0);
        step();
        chk("lat_n1", 64'(out_valid[0]), 64'd0);
        step();
        chk("lat_n2_valid", 64'(out_valid[0]), 64'd1);
        chk("lat_n2_data",  64'(out_data[7:0]), 64'h5A);
        step();
        chk("lat_n3", 64'(out_valid[0]), 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("mid_rst_quiet", 64'(out_valid), 64'd0);
            step();
        end

        for (int c = 0; c < CH; c++) begin
            wait_empty(c);
            chk($sformatf("sb_empty_ch%0d", c), 64'(sbq[c].size()), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
